// File: rtl/add_fit_pkg.sv
// add_fit_pkg: shared types for the add-and-fit clamp controller.
// Holds the FSM state encoding and the reduction mode codes.
package add_fit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Reduction mode selected by mode_i at start.
    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_SHR = 1'b1;

endpackage

// File: rtl/add_fit_cmp.sv
// add_fit_cmp: widened adder plus fit flag for the clamp controller.
// Ports: i_base, i_val (W) in; o_sum (W+1) full sum, o_fit = sum fits in W bits.
module add_fit_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_base,
    input  logic [W-1:0] i_val,
    output logic [W:0]   o_sum,
    output logic         o_fit
);

    assign o_sum = {1'b0, i_base} + {1'b0, i_val};

    // Carry out of the W-bit field means the sum does not fit.
    assign o_fit = ~o_sum[W];

endmodule

// File: rtl/add_fit_ctrl.sv
// add_fit_ctrl: reduce val until base+val fits in W bits or MAX_ITER is hit.
// Ports: clk, rst_n, start_i/base_i/val_i/mode_i in; busy_o, done_o,
//   val_o, sum_o, iter_o, timeout_o out (all registered).
module add_fit_ctrl
    import add_fit_pkg::*;
#(
    parameter int W        = 4,
    parameter int STEP     = 1,
    parameter int MAX_ITER = 15,
    localparam int IW      = $clog2(MAX_ITER + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [W-1:0]  base_i,
    input  logic [W-1:0]  val_i,
    input  logic          mode_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [W-1:0]  val_o,
    output logic [W-1:0]  sum_o,
    output logic [IW-1:0] iter_o,
    output logic          timeout_o
);

    localparam logic [W-1:0]  LP_STEP = W'(STEP);
    localparam logic [IW-1:0] LP_MAX  = IW'(MAX_ITER);

    state_t        r_state;
    logic [W-1:0]  r_base;
    logic [W-1:0]  r_val;
    logic          r_mode;
    logic [IW-1:0] r_iter;
    logic          r_busy;
    logic          r_done;
    logic [W-1:0]  r_sum;
    logic          r_tmo;

    logic [W:0]    w_sum;
    logic          w_fit;
    logic [W-1:0]  w_sum_sat;
    logic [W-1:0]  w_next_val;

    add_fit_cmp #(
        .W(W)
    ) u_cmp (
        .i_base (r_base),
        .i_val  (r_val),
        .o_sum  (w_sum),
        .o_fit  (w_fit)
    );

    // An overflowing sum saturates; this also gives the timeout value,
    // since a timeout only happens when the sum does not fit.
    assign w_sum_sat = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];

    // Next working value; subtraction clamps at zero.
    always_comb begin
        w_next_val = '0;
        if (r_mode == MODE_SHR) begin
            w_next_val = r_val >> 1;
        end else if (r_val > LP_STEP) begin
            w_next_val = r_val - LP_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_val   <= '0;
            r_mode  <= MODE_SUB;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_base  <= base_i;
                        r_val   <= val_i;
                        r_mode  <= mode_i;
                        r_iter  <= '0;
                        r_tmo   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_fit) begin
                        r_sum   <= w_sum_sat;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_iter == LP_MAX) begin
                        r_sum   <= w_sum_sat;
                        r_tmo   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_val  <= w_next_val;
                        r_iter <= r_iter + IW'(1);
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign val_o     = r_val;
    assign sum_o     = r_sum;
    assign iter_o    = r_iter;
    assign timeout_o = r_tmo;

endmodule

// File: tb/tb_add_fit_ctrl.sv
// tb_add_fit_ctrl: scoreboard bench for add_fit_ctrl over three parameter sets.
// d0: STEP=1 MAX_ITER=15, d1: STEP=1 MAX_ITER=3, d2: STEP=4 MAX_ITER=15.
module tb_add_fit_ctrl;

    typedef struct {
        int val;
        int sum;
        int iter;
        int tmo;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = '0;
    logic [3:0] base = '0;
    logic [3:0] val = '0;
    logic       mode = 1'b0;

    logic       bz0, bz1, bz2;
    logic       dn0, dn1, dn2;
    logic [3:0] vo0, vo1, vo2;
    logic [3:0] so0, so1, so2;
    logic [3:0] it0, it2;
    logic [1:0] it1;
    logic       to0, to1, to2;

    int   sel = 0;
    logic g_busy, g_done, g_tmo;
    int   g_val, g_sum, g_iter;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    add_fit_ctrl #(.W(4), .STEP(1), .MAX_ITER(15)) d0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]),
        .base_i(base), .val_i(val), .mode_i(mode),
        .busy_o(bz0), .done_o(dn0), .val_o(vo0), .sum_o(so0),
        .iter_o(it0), .timeout_o(to0)
    );

    add_fit_ctrl #(.W(4), .STEP(1), .MAX_ITER(3)) d1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]),
        .base_i(base), .val_i(val), .mode_i(mode),
        .busy_o(bz1), .done_o(dn1), .val_o(vo1), .sum_o(so1),
        .iter_o(it1), .timeout_o(to1)
    );

    add_fit_ctrl #(.W(4), .STEP(4), .MAX_ITER(15)) d2 (
        .clk(clk), .rst_n(rst_n), .start_i(start[2]),
        .base_i(base), .val_i(val), .mode_i(mode),
        .busy_o(bz2), .done_o(dn2), .val_o(vo2), .sum_o(so2),
        .iter_o(it2), .timeout_o(to2)
    );

    always_comb begin
        g_busy = bz0; g_done = dn0; g_tmo = to0;
        g_val = int'(vo0); g_sum = int'(so0); g_iter = int'(it0);
        if (sel == 1) begin
            g_busy = bz1; g_done = dn1; g_tmo = to1;
            g_val = int'(vo1); g_sum = int'(so1); g_iter = int'(it1);
        end else if (sel == 2) begin
            g_busy = bz2; g_done = dn2; g_tmo = to2;
            g_val = int'(vo2); g_sum = int'(so2); g_iter = int'(it2);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: reduce until base+val fits in 4 bits or mx reductions done.
    function automatic exp_t model(input int b, input int v, input int m,
                                   input int step, input int mx);
        exp_t e;
        int   it;
        it    = 0;
        e.tmo = 0;
        e.sum = 0;
        for (int k = 0; k < 64; k++) begin
            if (b + v <= 15) begin
                e.sum = b + v;
                break;
            end
            if (it == mx) begin
                e.tmo = 1;
                e.sum = 15;
                break;
            end
            if (m != 0) v = v >> 1;
            else v = (v > step) ? v - step : 0;
            it++;
        end
        e.val  = v;
        e.iter = it;
        e.lat  = it + 2;
        return e;
    endfunction

    task automatic do_op(input int idx, input int b, input int v,
                         input int m, input bit poke);
        exp_t ex;
        int   edges;
        bit   got;
        int   step;
        int   mx;
        step = (idx == 2) ? 4 : 1;
        mx   = (idx == 1) ? 3 : 15;
        q.push_back(model(b, v, m, step, mx));
        sel = idx;
        @(negedge clk);
        base = 4'(b);
        val  = 4'(v);
        mode = 1'(m);
        start[idx] = 1'b1;
        @(posedge clk);
        #1;
        start = '0;
        edges = 1;
        chk("busy_after_start", int'(g_busy), 1);
        got = 0;
        while (!got && edges < 64) begin
            if (poke && edges == 1) begin
                base = 4'd15;
                val  = 4'd15;
                mode = 1'b0;
                start[idx] = 1'b1;
            end
            @(posedge clk);
            #1;
            start = '0;
            edges++;
            if (g_done) got = 1;
        end
        ex = q.pop_front();
        if (!got) begin
            chk("done_wait_expired", 0, 1);
        end else begin
            chk("latency", edges, ex.lat);
            chk("val_o", g_val, ex.val);
            chk("sum_o", g_sum, ex.sum);
            chk("iter_o", g_iter, ex.iter);
            chk("timeout_o", int'(g_tmo), ex.tmo);
            chk("busy_at_done", int'(g_busy), 1);
            @(posedge clk);
            #1;
            chk("done_one_cycle", int'(g_done), 0);
            chk("busy_cleared", int'(g_busy), 0);
            if (poke) begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("no_queued_done", int'(g_done | g_busy), 0);
                end
                chk("held_val", g_val, ex.val);
                chk("held_sum", g_sum, ex.sum);
            end
            chk("held_timeout", int'(g_tmo), ex.tmo);
        end
    endtask

    int seen;

    initial begin
        sel = 0;
        #12;
        chk("rst_busy", int'(bz0 | bz1 | bz2), 0);
        chk("rst_done", int'(dn0 | dn1 | dn2), 0);
        chk("rst_val", int'(vo0 | vo1 | vo2), 0);
        chk("rst_sum", int'(so0 | so1 | so2), 0);
        chk("rst_iter", int'(it0 | it2) + int'(it1), 0);
        chk("rst_tmo", int'(to0 | to1 | to2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(0, 10, 10, 0, 1'b0);
        do_op(0, 3, 4, 0, 1'b1);
        do_op(0, 12, 15, 1, 1'b0);
        do_op(1, 15, 15, 0, 1'b0);
        do_op(2, 14, 2, 0, 1'b0);
        do_op(1, 2, 3, 1, 1'b0);
        do_op(2, 9, 15, 1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_op(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  1'b0);
        end

        // Reset mid-CHECK: abandon the operation, no done afterwards.
        sel = 0;
        @(negedge clk);
        base = 4'd10;
        val  = 4'd10;
        mode = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_busy", int'(g_busy), 1);
        chk("pre_rst_val", g_val, 10 - 3);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(g_busy), 0);
        chk("arst_val", g_val, 0);
        chk("arst_iter", g_iter, 0);
        chk("arst_sum", g_sum + int'(g_tmo) + int'(g_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (g_done || g_busy) seen++;
        end
        chk("no_done_after_rst", seen, 0);

        do_op(0, 10, 10, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
